// File: rtl/rect_sum_reader.sv
// rect_sum_reader: fetches 4 ii corners per Haar rectangle and accumulates weighted rectangle sums per feature
module rect_sum_reader #(
  parameter int W_II          = 18,
  parameter int WINDOW_WIDTH  = 24,
  parameter int WINDOW_HEIGHT = 24,
  parameter int W_ADDR        = 10,
  parameter int W_COORD       = 5,
  parameter int W_WEIGHT      = 3,
  parameter int W_FEAT        = W_II + W_WEIGHT + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rect_valid,
  output logic                       rect_ready,
  input  logic [4*W_COORD-1:0]       rect_data,
  input  logic [W_WEIGHT-1:0]        rect_weight,
  input  logic                       rect_last,
  output logic                       ii_addr_valid,
  input  logic                       ii_addr_ready,
  output logic [W_ADDR-1:0]          ii_addr_data,
  input  logic                       ii_dout_valid,
  output logic                       ii_dout_ready,
  input  logic [W_II-1:0]            ii_dout_data,
  output logic                       feature_valid,
  input  logic                       feature_ready,
  output logic [W_FEAT-1:0]          feature_data,
  output logic                       rect_err
);
  typedef enum logic [1:0] {IDLE, FETCH, ACC, OUT} state_t;
  state_t state;
  logic [W_COORD-1:0] in_x0, in_y0, in_x1, in_y1;
  logic [W_COORD-1:0] x0, y0, x1, y1, ax, ay;
  logic signed [W_WEIGHT-1:0] weight;
  logic last, bad, err_q;
  logic [2:0] issued, received;
  logic [W_II-1:0] corner [4];
  logic [W_II-1:0] rsum;
  logic signed [W_FEAT-1:0] acc, w_ext, r_ext, term;
  assign {in_y1, in_x1, in_y0, in_x0} = rect_data;
  assign bad = (in_x1 <= in_x0) || (in_y1 <= in_y0) ||
               (32'(in_x1) >= WINDOW_WIDTH) || (32'(in_y1) >= WINDOW_HEIGHT);
  assign ay = issued[1] ? y1 : y0;
  assign ax = issued[0] ? x1 : x0;
  assign ii_addr_data  = W_ADDR'(ay) * W_ADDR'(WINDOW_WIDTH) + W_ADDR'(ax);
  assign rect_ready    = rst && state == IDLE;
  assign ii_addr_valid = rst && state == FETCH && !issued[2];
  assign ii_dout_ready = rst && state == FETCH && !received[2];
  assign feature_valid = rst && state == OUT;
  assign feature_data  = acc;
  assign rect_err      = rst && err_q;
  assign rsum  = corner[3] - corner[1] - corner[2] + corner[0];
  assign w_ext = W_FEAT'(weight);
  assign r_ext = W_FEAT'(rsum);
  assign term  = w_ext * r_ext;
  // Rectangle intake, corner fetch/collect, weighted accumulation and feature hand-off
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      issued   <= '0;
      received <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: if (rect_valid) begin
          {x0, y0, x1, y1} <= {in_x0, in_y0, in_x1, in_y1};
          weight <= rect_weight;
          last   <= rect_last;
          err_q  <= bad;
          state  <= !bad ? FETCH : rect_last ? OUT : IDLE;
        end
        FETCH: begin
          if (ii_addr_valid && ii_addr_ready) issued <= issued + 3'd1;
          if (ii_dout_valid && ii_dout_ready) begin
            corner[received[1:0]] <= ii_dout_data;
            received <= received + 3'd1;
            if (received == 3'd3) state <= ACC;
          end
        end
        ACC: begin
          acc      <= acc + term;
          issued   <= '0;
          received <= '0;
          state    <= last ? OUT : IDLE;
        end
        OUT: if (feature_ready) begin
          acc   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_sum_reader.sv
// tb_rect_sum_reader: randomized bench with a pixel-level reference model for rect_sum_reader
module tb_rect_sum_reader;
  localparam int W_II = 18, WW = 24, WH = 24, W_ADDR = 10, W_COORD = 5, W_WEIGHT = 3;
  localparam int W_FEAT = W_II + W_WEIGHT + 2;
  logic clk = 0, rst = 0;
  logic rect_valid, rect_ready, rect_last, ii_addr_valid, ii_addr_ready;
  logic ii_dout_valid, ii_dout_ready, feature_valid, feature_ready, rect_err;
  logic [4*W_COORD-1:0] rect_data;
  logic [W_WEIGHT-1:0] rect_weight;
  logic [W_ADDR-1:0] ii_addr_data;
  logic [W_II-1:0] ii_dout_data;
  logic [W_FEAT-1:0] feature_data;
  always #5 clk = ~clk;
  rect_sum_reader #(.W_II(W_II), .WINDOW_WIDTH(WW), .WINDOW_HEIGHT(WH), .W_ADDR(W_ADDR),
    .W_COORD(W_COORD), .W_WEIGHT(W_WEIGHT), .W_FEAT(W_FEAT)) dut (
    .clk(clk), .rst(rst), .rect_valid(rect_valid), .rect_ready(rect_ready),
    .rect_data(rect_data), .rect_weight(rect_weight), .rect_last(rect_last),
    .ii_addr_valid(ii_addr_valid), .ii_addr_ready(ii_addr_ready), .ii_addr_data(ii_addr_data),
    .ii_dout_valid(ii_dout_valid), .ii_dout_ready(ii_dout_ready), .ii_dout_data(ii_dout_data),
    .feature_valid(feature_valid), .feature_ready(feature_ready), .feature_data(feature_data),
    .rect_err(rect_err));
  int errors = 0, checks = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // image model: pixels, and the ii memory the window buffer serves
  int pix [WH][WW];
  logic [W_II-1:0] mem [WH*WW];
  task automatic load_image(bit rnd);
    int s;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++) pix[r][c] = rnd ? int'($urandom_range(0, 255)) : 1;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++) begin
        s = 0;
        for (int rr = 0; rr <= r; rr++)
          for (int cc = 0; cc <= c; cc++) s += pix[rr][cc];
        mem[r*WW+c] = W_II'(s);
      end
  endtask
  function automatic longint pixel_sum(int x0, int y0, int x1, int y1);
    longint s = 0;
    for (int r = y0 + 1; r <= y1; r++)
      for (int c = x0 + 1; c <= x1; c++) s += pix[r][c];
    return s;
  endfunction
  // window buffer responder: 1-cycle read, in-order returns, optional random stalls
  bit stall = 0;
  logic [W_ADDR-1:0] pend [$];
  initial begin
    ii_addr_ready = 0; ii_dout_valid = 0; ii_dout_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) pend.delete();
      else begin
        if (ii_dout_valid && ii_dout_ready) void'(pend.pop_front());
        if (ii_addr_valid && ii_addr_ready) pend.push_back(ii_addr_data);
      end
      @(posedge clk); #1;
      ii_addr_ready = stall ? 1'($urandom % 2) : 1'b1;
      ii_dout_valid = pend.size() > 0 && (!stall || ($urandom % 2) == 1);
      ii_dout_data  = pend.size() > 0 ? mem[pend[0]] : '0;
    end
  end
  // monitor: collect issued addresses, features, error pulses and timing
  logic [W_ADDR-1:0] addr_got [$];
  logic [W_FEAT-1:0] feat_got [$];
  int err_got = 0, cyc = 0, acc_cyc = 0, fv_cyc = 0;
  bit prev_hold = 0, prev_fv = 0;
  logic [W_ADDR-1:0] prev_addr;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (prev_hold) begin
        check("addr_hold_valid", ii_addr_valid, 1);
        check("addr_hold_data", ii_addr_data, prev_addr);
      end
      prev_hold = ii_addr_valid && !ii_addr_ready;
      prev_addr = ii_addr_data;
      if (ii_addr_valid && ii_addr_ready) addr_got.push_back(ii_addr_data);
      if (feature_valid && feature_ready) feat_got.push_back(feature_data);
      if (rect_err) err_got++;
      if (rect_valid && rect_ready) acc_cyc = cyc;
      if (feature_valid && !prev_fv) fv_cyc = cyc;
      prev_fv = feature_valid;
    end else begin
      prev_hold = 0;
      prev_fv = 0;
    end
  end
  // reference expectations
  longint model_acc = 0;
  logic [W_ADDR-1:0] exp_addr [$];
  logic [W_FEAT-1:0] exp_feat [$];
  int exp_err = 0;
  task automatic send(int x0, int y0, int x1, int y1, int w, bit last);
    bit ok;
    ok = 0;
    rect_data = {W_COORD'(y1), W_COORD'(x1), W_COORD'(y0), W_COORD'(x0)};
    rect_weight = W_WEIGHT'(w);
    rect_last = last;
    rect_valid = 1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = rect_ready;
      @(posedge clk); #1;
    end
    rect_valid = 0;
    if (!ok) check("rect_accept_timeout", 0, 1);
  endtask
  task automatic add_rect(int x0, int y0, int x1, int y1, int w, bit last);
    if (x1 <= x0 || y1 <= y0 || x1 >= WW || y1 >= WH) exp_err++;
    else begin
      model_acc += w * pixel_sum(x0, y0, x1, y1);
      exp_addr.push_back(W_ADDR'(y0*WW + x0));
      exp_addr.push_back(W_ADDR'(y0*WW + x1));
      exp_addr.push_back(W_ADDR'(y1*WW + x0));
      exp_addr.push_back(W_ADDR'(y1*WW + x1));
    end
    if (last) begin
      exp_feat.push_back(W_FEAT'(model_acc));
      model_acc = 0;
    end
    send(x0, y0, x1, y1, w, last);
  endtask
  task automatic drain(string tag);
    for (int n = 0; n < 4000 && feat_got.size() < exp_feat.size(); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check({tag, "_nfeat"}, feat_got.size(), exp_feat.size());
    for (int i = 0; i < exp_feat.size() && i < feat_got.size(); i++)
      check({tag, "_feat"}, feat_got[i], exp_feat[i]);
    check({tag, "_naddr"}, addr_got.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < addr_got.size(); i++)
      check({tag, "_addr"}, addr_got[i], exp_addr[i]);
    check({tag, "_err"}, err_got, exp_err);
    feat_got.delete(); exp_feat.delete(); addr_got.delete(); exp_addr.delete();
    err_got = 0; exp_err = 0;
  endtask
  task automatic check_quiet(string tag);
    check({tag, "_rect_ready"}, rect_ready, 0);
    check({tag, "_addr_valid"}, ii_addr_valid, 0);
    check({tag, "_dout_ready"}, ii_dout_ready, 0);
    check({tag, "_feature_valid"}, feature_valid, 0);
    check({tag, "_rect_err"}, rect_err, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nr, x0, y0, x1, y1, k;
    bit seen;
    rect_valid = 0; rect_data = '0; rect_weight = '0; rect_last = 0; feature_ready = 1;
    load_image(0);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("idle_rect_ready", rect_ready, 1);
    check("idle_feature_valid", feature_valid, 0);
    @(posedge clk); #1;
    // all-ones image, single rect: addresses 0,2,48,50 and sum 4
    add_rect(0, 0, 2, 2, 1, 1);
    drain("t1");
    check("t1_latency", fv_cyc - acc_cyc, 7);
    // two weighted rects in one feature: -16 + 8
    add_rect(0, 0, 4, 4, -1, 0);
    add_rect(0, 0, 2, 2, 2, 1);
    drain("t2");
    // malformed rect as last: error pulse, no reads, zero feature
    add_rect(3, 0, 3, 2, 1, 1);
    drain("t3");
    // same as t2 under random address/data stalls
    stall = 1;
    add_rect(0, 0, 4, 4, -1, 0);
    add_rect(0, 0, 2, 2, 2, 1);
    drain("t4");
    stall = 0;
    // downstream back-pressure holds the feature
    feature_ready = 0;
    add_rect(0, 0, 2, 2, 1, 1);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = feature_valid;
    end
    check("t5_feature_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", feature_valid, 1);
      check("t5_hold_data", feature_data, W_FEAT'(4));
      check("t5_rect_ready", rect_ready, 0);
      check("t5_no_reads", ii_addr_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    feature_ready = 1;
    drain("t5");
    // reset after the second address of a rect
    send(0, 0, 4, 4, 1, 1);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = addr_got.size() >= 2;
    end
    check("t6_two_addrs", seen, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_quiet("t6");
    @(posedge clk); #1;
    rst = 1;
    addr_got.delete();
    feat_got.delete();
    err_got = 0;
    add_rect(0, 0, 2, 2, 1, 1);
    drain("t6");
    // random image, random rects (some malformed), random stalls
    load_image(1);
    stall = 1;
    for (int f = 0; f < 25; f++) begin
      nr = int'($urandom_range(1, 4));
      for (int r = 0; r < nr; r++) begin
        x0 = int'($urandom_range(0, 22)); x1 = int'($urandom_range(x0 + 1, 23));
        y0 = int'($urandom_range(0, 22)); y1 = int'($urandom_range(y0 + 1, 23));
        k = int'($urandom_range(0, 9));
        if (k == 0) x1 = x0;
        if (k == 1) y1 = int'($urandom_range(24, 31));
        if (k == 2) begin y1 = y0; y0 = int'($urandom_range(y1, 23)); end
        add_rect(x0, y0, x1, y1, int'($urandom_range(0, 7)) - 4, r == nr - 1);
      end
    end
    drain("rand");
    stall = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
